// File: rtl/sha_round_ctrl.sv
// -----------------------------------------------------------------------------
// sha_round_ctrl
//
// Round-sequencing controller for SHA-family compression cores. It accepts a
// first-block (init) or chained-block (next) command, then steps the datapath
// through LOAD, NUM_ROUNDS/UNROLL round cycles and a FINAL digest-accumulate
// cycle. The controller also supports abort and keeps a sticky digest-valid
// flag.
//
// Parameters:
//   NUM_ROUNDS  total compression rounds per block (multiple of UNROLL)
//   UNROLL      rounds executed by the datapath per clock (1, 2, 4 or 8)
//   CNT_W       width of the round index (derived)
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   init           start a new message (IV load into digest, then block)
//   next           process a chained block from current digest
//   abort          drop the block in progress, no digest write
//   round          index of first round processed this cycle
//   w_load         load 16-word block into message schedule
//   ah_load        copy digest registers into working registers a..h
//   ah_update      advance working registers by UNROLL rounds
//   digest_init    load IV constants into digest registers
//   digest_we      accumulate a..h into digest registers
//   ready          idle; init/next accepted this cycle
//   digest_valid   digest registers hold a completed result
//   blk_cnt        (only with SHA_ROUND_CTRL_BLKCNT_EN) blocks completed
//                  since the last init, saturating
//
// Optional feature macro: SHA_ROUND_CTRL_BLKCNT_EN
// -----------------------------------------------------------------------------
module sha_round_ctrl #(
    parameter  int NUM_ROUNDS = 64,
    parameter  int UNROLL     = 1,
    localparam int CNT_W      = $clog2(NUM_ROUNDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             next,
    input  logic             abort,
    output logic [CNT_W-1:0] round,
    output logic             w_load,
    output logic             ah_load,
    output logic             ah_update,
    output logic             digest_init,
    output logic             digest_we,
    output logic             ready,
    output logic             digest_valid
`ifdef SHA_ROUND_CTRL_BLKCNT_EN
    ,
    output logic [31:0]      blk_cnt
`endif
);

    // Elaboration-time parameter checks.
    if (NUM_ROUNDS < 2 || (NUM_ROUNDS % UNROLL) != 0) begin : g_bad_rounds
        $error("sha_round_ctrl: NUM_ROUNDS must be >= 2 and a multiple of UNROLL");
    end
    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
        $error("sha_round_ctrl: UNROLL must be 1, 2, 4 or 8");
    end

    localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(NUM_ROUNDS - UNROLL);
    localparam logic [CNT_W-1:0] ROUND_STEP = CNT_W'(UNROLL);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ROUNDS,
        S_FINAL
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] round_q, round_d;
    logic             valid_q, valid_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            round_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        valid_d     = valid_q;
        w_load      = 1'b0;
        ah_load     = 1'b0;
        ah_update   = 1'b0;
        digest_init = 1'b0;
        digest_we   = 1'b0;

        case (state_q)
            S_IDLE: begin
                round_d = '0;
                // abort takes priority over a coincident command
                if (abort) begin
                    valid_d = 1'b0;
                end else if (init) begin
                    digest_init = 1'b1;
                    valid_d     = 1'b0;
                    state_d     = S_LOAD;
                end else if (next) begin
                    valid_d = 1'b0;
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                round_d = '0;
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    w_load  = 1'b1;
                    ah_load = 1'b1;
                    state_d = S_ROUNDS;
                end
            end

            S_ROUNDS: begin
                if (abort) begin
                    round_d = '0;
                    state_d = S_IDLE;
                end else begin
                    ah_update = 1'b1;
                    // leave at the terminal index so the counter never wraps
                    if (round_q == LAST_ROUND) begin
                        round_d = '0;
                        state_d = S_FINAL;
                    end else begin
                        round_d = round_q + ROUND_STEP;
                    end
                end
            end

            S_FINAL: begin
                round_d = '0;
                state_d = S_IDLE;
                if (!abort) begin
                    digest_we = 1'b1;
                    valid_d   = 1'b1;
                end
            end

            default: begin
                round_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign ready        = (state_q == S_IDLE);
    assign round        = round_q;
    assign digest_valid = valid_q;

`ifdef SHA_ROUND_CTRL_BLKCNT_EN
    logic [31:0] blk_cnt_q, blk_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt_q <= '0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
        end
    end

    // Only completed (non-aborted) FINAL cycles count; saturate at all-ones.
    always_comb begin
        blk_cnt_d = blk_cnt_q;
        if (state_q == S_IDLE && !abort && init) begin
            blk_cnt_d = '0;
        end else if (digest_we && blk_cnt_q != 32'hFFFF_FFFF) begin
            blk_cnt_d = blk_cnt_q + 32'd1;
        end
    end

    assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_sha_round_ctrl.sv
module tb_sha_round_ctrl;

    logic clk;
    logic rst;

    logic in_init  [3];
    logic in_next  [3];
    logic in_abort [3];

    logic [5:0] r0;
    logic [5:0] r4;
    logic [6:0] r80;
    logic wl [3];
    logic al [3];
    logic au [3];
    logic di [3];
    logic dw [3];
    logic rdy[3];
    logic dv [3];
`ifdef SHA_ROUND_CTRL_BLKCNT_EN
    logic [31:0] blk [3];
`endif

    logic [14:0] obs [3];

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // inst 0: 64 rounds x1, inst 1: 64 rounds x4, inst 2: 80 rounds x1
    sha_round_ctrl #(.NUM_ROUNDS(64), .UNROLL(1)) u0 (
        .clk(clk), .rst(rst), .init(in_init[0]), .next(in_next[0]), .abort(in_abort[0]),
        .round(r0), .w_load(wl[0]), .ah_load(al[0]), .ah_update(au[0]),
        .digest_init(di[0]), .digest_we(dw[0]), .ready(rdy[0]), .digest_valid(dv[0])
`ifdef SHA_ROUND_CTRL_BLKCNT_EN
        , .blk_cnt(blk[0])
`endif
    );

    sha_round_ctrl #(.NUM_ROUNDS(64), .UNROLL(4)) u4 (
        .clk(clk), .rst(rst), .init(in_init[1]), .next(in_next[1]), .abort(in_abort[1]),
        .round(r4), .w_load(wl[1]), .ah_load(al[1]), .ah_update(au[1]),
        .digest_init(di[1]), .digest_we(dw[1]), .ready(rdy[1]), .digest_valid(dv[1])
`ifdef SHA_ROUND_CTRL_BLKCNT_EN
        , .blk_cnt(blk[1])
`endif
    );

    sha_round_ctrl #(.NUM_ROUNDS(80), .UNROLL(1)) u80 (
        .clk(clk), .rst(rst), .init(in_init[2]), .next(in_next[2]), .abort(in_abort[2]),
        .round(r80), .w_load(wl[2]), .ah_load(al[2]), .ah_update(au[2]),
        .digest_init(di[2]), .digest_we(dw[2]), .ready(rdy[2]), .digest_valid(dv[2])
`ifdef SHA_ROUND_CTRL_BLKCNT_EN
        , .blk_cnt(blk[2])
`endif
    );

    assign obs[0] = {2'b00, r0,  wl[0], al[0], au[0], di[0], dw[0], rdy[0], dv[0]};
    assign obs[1] = {2'b00, r4,  wl[1], al[1], au[1], di[1], dw[1], rdy[1], dv[1]};
    assign obs[2] = {1'b0,  r80, wl[2], al[2], au[2], di[2], dw[2], rdy[2], dv[2]};

    typedef struct {
        logic        rst_i;
        logic        init_i;
        logic        next_i;
        logic        abort_i;
        logic [14:0] exp;
    } vec_t;

    vec_t tbl[$];

    // Expected output word: {round, w_load, ah_load, ah_update, digest_init,
    // digest_we, ready, digest_valid}
    function automatic logic [14:0] ex(input int rnd, input bit wl_e, input bit al_e,
                                       input bit au_e, input bit di_e, input bit dw_e,
                                       input bit rdy_e, input bit dv_e);
        logic [7:0] r8;
        r8 = rnd[7:0];
        return {r8, wl_e, al_e, au_e, di_e, dw_e, rdy_e, dv_e};
    endfunction

    function automatic void push(input bit r, input bit i, input bit n, input bit a,
                                 input logic [14:0] e);
        tbl.push_back('{rst_i: r, init_i: i, next_i: n, abort_i: a, exp: e});
    endfunction

    // Appends the cycle-by-cycle timeline of one block (command at cycle 0,
    // LOAD at 1, rounds at 2..N+1, FINAL at N+2, idle at N+3). kill_cyc
    // injects an abort (or rst when kill_rst) at that cycle; stray_cyc drives
    // an ignored next. Returns digest_valid after the block.
    function automatic bit add_block(input int nr, input int u, input bit c_init,
                                     input bit c_next, input bit dv_prev,
                                     input int kill_cyc, input bit kill_rst,
                                     input int stray_cyc);
        int n;
        bit k, ab, rs, nx;
        logic [14:0] e;
        n = nr / u;
        push(1'b0, c_init, c_next, 1'b0, ex(0, 0, 0, 0, c_init, 0, 1, dv_prev));
        for (int c = 1; c <= n + 2; c++) begin
            k  = (c == kill_cyc);
            ab = k && !kill_rst;
            rs = k && kill_rst;
            nx = (c == stray_cyc);
            if (c == 1)          e = ex(0, !ab, !ab, 0, 0, 0, 0, 0);
            else if (c <= n + 1) e = ex((c - 2) * u, 0, 0, !ab, 0, 0, 0, 0);
            else                 e = ex(0, 0, 0, 0, 0, !ab, 0, 0);
            push(rs, 1'b0, nx, ab, e);
            if (k) begin
                push(1'b0, 1'b0, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 0, 1, 0));
                return 1'b0;
            end
        end
        push(1'b0, 1'b0, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 0, 1, 1));
        return 1'b1;
    endfunction

    task automatic run_tbl(input int inst, input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst            = tbl[i].rst_i;
            in_init[inst]  = tbl[i].init_i;
            in_next[inst]  = tbl[i].next_i;
            in_abort[inst] = tbl[i].abort_i;
            #1;
            checks++;
            if (obs[inst] !== tbl[i].exp) begin
                errors++;
                $display("FAIL %s row %0d: got %h expected %h", name, i, obs[inst], tbl[i].exp);
            end
        end
        in_init[inst]  = 1'b0;
        in_next[inst]  = 1'b0;
        in_abort[inst] = 1'b0;
        tbl.delete();
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    bit dv0, dv4, dv80;

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_init[k]  = 1'b0;
            in_next[k]  = 1'b0;
            in_abort[k] = 1'b0;
        end
        dv0 = 0; dv4 = 0; dv80 = 0;

        // reset state on every instance
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++)
            check_val($sformatf("reset_inst%0d", k), 32'(obs[k]), 32'(ex(0, 0, 0, 0, 0, 0, 1, 0)));
        rst = 1'b0;

        // full init block, 64 rounds x1
        dv0 = add_block(64, 1, 1, 0, dv0, -1, 0, -1);
        run_tbl(0, "init_64x1");

        // chained block, 64 rounds x4, digest_init never asserted
        dv4 = add_block(64, 4, 0, 1, dv4, -1, 0, -1);
        run_tbl(1, "next_64x4");

        // abort at round 30, in LOAD, in FINAL; then a clean init
        dv0 = add_block(64, 1, 0, 1, dv0, 32, 0, -1);
        dv0 = add_block(64, 1, 0, 1, dv0, 1, 0, -1);
        dv0 = add_block(64, 1, 0, 1, dv0, 66, 0, -1);
        dv0 = add_block(64, 1, 1, 0, dv0, -1, 0, -1);
        run_tbl(0, "abort_seq");

        // init+next together, stray next during rounds
        dv0 = add_block(64, 1, 1, 1, dv0, -1, 0, 10);
        run_tbl(0, "init_next_both");

        // abort in IDLE beats init/next and clears digest_valid
        push(1'b0, 1'b1, 1'b0, 1'b1, ex(0, 0, 0, 0, 0, 0, 1, dv0));
        push(1'b0, 1'b0, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 0, 1, 0));
        push(1'b0, 1'b0, 1'b1, 1'b1, ex(0, 0, 0, 0, 0, 0, 1, 0));
        push(1'b0, 1'b0, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 0, 1, 0));
        run_tbl(0, "abort_idle");
        dv0 = 0;

`ifdef SHA_ROUND_CTRL_BLKCNT_EN
        dv0 = add_block(64, 1, 1, 0, dv0, -1, 0, -1);
        dv0 = add_block(64, 1, 0, 1, dv0, -1, 0, -1);
        dv0 = add_block(64, 1, 0, 1, dv0, -1, 0, -1);
        run_tbl(0, "blk_three");
        check_val("blk_cnt_after_3", blk[0], 32'd3);

        dv0 = add_block(64, 1, 0, 1, dv0, 20, 0, -1);
        run_tbl(0, "blk_abort");
        check_val("blk_cnt_after_abort", blk[0], 32'd3);

        @(negedge clk);
        in_init[0] = 1'b1;
        @(negedge clk);
        in_init[0] = 1'b0;
        #1;
        check_val("blk_cnt_cleared", blk[0], 32'd0);
        repeat (66) @(negedge clk);
        #1;
        check_val("blk_cnt_after_init", blk[0], 32'd1);
        check_val("dv_after_blk_init", 32'(dv[0]), 32'd1);
        dv0 = 1;
`endif

        // 80-round: rst at round 40, then a full init with digest_we at cycle 82
        dv80 = add_block(80, 1, 1, 0, dv80, 42, 1, -1);
        dv80 = add_block(80, 1, 1, 0, dv80, -1, 0, -1);
        run_tbl(2, "rst_and_80x1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha_round_ctrl.md
Name: sha_round_ctrl

Overview:
Parametrised round-sequencing controller for the SHA family of hash cores (SHA-256 with 64 rounds, SHA-512/SHA-1 with 80 rounds).
- Generalises the single-block control FSM with configurable round count and rounds-per-cycle unrolling.
- Distinguishes the first block of a message (IV load) from chained blocks.
- Adds abort and a sticky digest-valid flag.
- Sits between the host interface and the datapath: drives the message-schedule, a–h working-register and digest-register enables, and exports the current round index.

Parameters:
NUM_ROUNDS, 64, total compression rounds per block; must be a multiple of UNROLL (elaboration error otherwise).
UNROLL, 1, rounds the datapath executes per clock (1, 2, 4 or 8).
CNT_W, $clog2(NUM_ROUNDS), localparam; width of the round index.

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
init  input  1  start a new message: load IV into digest registers, then process block
next  input  1  process next block of current message, chaining from digest registers
abort  input  1  terminate block in progress; no digest write
round  output  CNT_W  index of first round processed this cycle
w_load  output  1  load 16-word block into message schedule
ah_load  output  1  copy digest registers H0..H7 into working registers a..h
ah_update  output  1  advance working registers by UNROLL rounds
digest_init  output  1  load IV constants into digest registers
digest_we  output  1  add a..h into digest registers
ready  output  1  controller idle, command accepted this cycle if init/next high
digest_valid  output  1  digest registers hold a completed result

Behaviour:
- States: IDLE, LOAD, ROUNDS, FINAL. N = NUM_ROUNDS/UNROLL.
- Reset: state IDLE; round=0; digest_valid=0; w_load, ah_load, ah_update, digest_init, digest_we all 0; ready=1. Reset mid-operation abandons the block with no digest_we.
- ready = (state==IDLE), combinational.
- IDLE:
  - init=1: digest_init=1 this cycle, digest_valid cleared, → LOAD.
  - else next=1: digest_valid cleared, → LOAD.
  - init and next both high: treated as init.
- LOAD (1 cycle): w_load=1, ah_load=1, round=0, → ROUNDS. ah_load samples the digest registers after the IDLE-cycle digest_init write.
- ROUNDS (N cycles): ah_update=1, round = 0, UNROLL, 2·UNROLL, … (NUM_ROUNDS−UNROLL). After the cycle with round == NUM_ROUNDS−UNROLL, → FINAL.
- FINAL (1 cycle): digest_we=1, round=0, → IDLE; digest_valid set on that transition.
- round = 0 in IDLE, LOAD and FINAL.
- Timing, with command accepted at cycle 0:
  - LOAD at cycle 1.
  - ROUNDS at cycles 2..N+1.
  - FINAL (digest_we) at cycle N+2.
  - ready=1 and digest_valid=1 at cycle N+3.
- init/next outside IDLE: ignored, no queuing.
- abort in LOAD, ROUNDS or FINAL:
  - → IDLE next cycle; all strobes forced 0 in the abort cycle (including digest_we in FINAL); digest_valid stays 0.
- abort in IDLE:
  - clears digest_valid; any init/next in the same cycle is ignored (abort wins).
- digest_valid: sticky; set leaving FINAL; cleared by accepted init/next, by abort, and by rst.
- Round counter: CNT_W bits, increments by UNROLL. It never wraps because the state changes at the terminal value.

Optional Feature:
SHA_ROUND_CTRL_BLKCNT_EN
- Defined: adds output blk_cnt [31:0], the number of blocks completed since the last init.
  - Reset 0; cleared to 0 on accepted init.
  - Incremented by 1 in each FINAL cycle whose digest_we=1 (aborted blocks not counted).
  - Saturates at 32'hFFFF_FFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Defaults, init pulse at cycle 0 → digest_init=1 @0; w_load=ah_load=1 @1; ah_update=1 @2..65 with round 0..63; digest_we=1 @66; ready=digest_valid=1 @67.
- UNROLL=4, NUM_ROUNDS=64, next pulse → round 0,4,…,60 over cycles 2..17; digest_we @18; digest_init never asserted.
- abort while round==30 → IDLE next cycle; no digest_we; digest_valid=0; ready=1; a following init completes normally.
- init and next high together in IDLE → digest_init=1; next asserted during ROUNDS → ignored, single digest_we observed.
- rst asserted at round 40 → all outputs at reset values next cycle; no digest_we; NUM_ROUNDS=80, UNROLL=1 run → digest_we at cycle 82.
- With SHA_ROUND_CTRL_BLKCNT_EN: init + 2×next → blk_cnt=3; one aborted next → still 3; new init → 0 at accept, 1 after FINAL.
